// File: rtl/ext_bus_pkg.sv
// Shared definitions for the external-bus target.
//   - state_e            : target FSM states
//   - CTRL_*             : bit positions of the synchronized control strobes
//   - LANE_*_BIT         : bit positions inside a 2-bit lane-enable vector
//   - DEFAULT_BASE_ADDR  : default decode base
//   - lane_enables()     : builds the lane-enable vector from A0 and BHE
package ext_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_DRIVE,
    ST_WR_ACTIVE
  } state_e;

  localparam int CTRL_ALE0 = 0;
  localparam int CTRL_ALE1 = 1;
  localparam int CTRL_OE   = 2;
  localparam int CTRL_WE   = 3;
  localparam int N_CTRL    = 4;

  localparam int LANE_LO_BIT = 0;
  localparam int LANE_HI_BIT = 1;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h00FF_0000;

  // Low byte is addressed by an even byte address, high byte by BHE.
  function automatic logic [1:0] lane_enables(input logic a0, input logic bhe_s);
    logic [1:0] en;
    en = '0;
    en[LANE_LO_BIT] = ~a0;
    en[LANE_HI_BIT] = bhe_s;
    return en;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer with edge detection for one asynchronous strobe.
//   clk, reset : system clock, synchronous active-high reset
//   d          : asynchronous input
//   s          : synchronized level (after STAGES flops)
//   rise, fall : single-cycle pulses comparing s against its delayed copy
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_reg;
  logic              prev_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d};
      prev_reg <= sync_reg[STAGES-1];
    end
  end

  assign s    = sync_reg[STAGES-1];
  assign rise = s & ~prev_reg;
  assign fall = ~s & prev_reg;

endmodule

// File: rtl/ext_bus_target.sv
// Target side of the multiplexed 16-bit external SRAM bus.
// Latches a 32-bit byte address in two halves (ALE0 low, ALE1 high), decodes
// it against BASE_ADDR and serves OE reads / WE writes from a halfword memory
// with BHE/A0 byte lanes. All bus inputs are asynchronous and synchronized.
//   clk, reset      : system clock, synchronous active-high reset
//   din             : pad data/address in
//   dout, isout     : pad read data and its output enable
//   ale0, ale1      : address latch enables (low / high half)
//   oe, we, bhe     : read strobe, write strobe, high byte enable
//   dbg_addr/dbg_dtr: independent read-only port, 1-cycle registered latency
//   bus_err         : sticky protocol-error flag
module ext_bus_target
  import ext_bus_pkg::*;
#(
  parameter int          MEM_AW      = 8,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          READ_LAT    = 1,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       din,
  output logic [15:0]       dout,
  output logic              isout,
  input  logic              ale0,
  input  logic              ale1,
  input  logic              oe,
  input  logic              we,
  input  logic              bhe,
  input  logic [MEM_AW-1:0] dbg_addr,
  output logic [15:0]       dbg_dtr,
  output logic              bus_err
);

  localparam int CNT_W = $clog2(READ_LAT + 1);

  // ---------------- input synchronization ----------------
  logic [N_CTRL-1:0] ctrl_in, ctrl_s, ctrl_rise, ctrl_fall;

  assign ctrl_in[CTRL_ALE0] = ale0;
  assign ctrl_in[CTRL_ALE1] = ale1;
  assign ctrl_in[CTRL_OE]   = oe;
  assign ctrl_in[CTRL_WE]   = we;

  genvar gi;
  generate
    for (gi = 0; gi < N_CTRL; gi++) begin : g_ctrl_sync
      sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (ctrl_in[gi]),
        .s    (ctrl_s[gi]),
        .rise (ctrl_rise[gi]),
        .fall (ctrl_fall[gi])
      );
    end
  endgenerate

  // din and bhe share one chain so they stay aligned with the strobes.
  logic [16:0] data_sync_reg [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) data_sync_reg[i] <= '0;
    end else begin
      data_sync_reg[0] <= {bhe, din};
      for (int i = 1; i < SYNC_STAGES; i++) data_sync_reg[i] <= data_sync_reg[i-1];
    end
  end

  logic [15:0] din_s;
  logic        bhe_s;
  assign {bhe_s, din_s} = data_sync_reg[SYNC_STAGES-1];

  logic oe_s, oe_rise, oe_fall, we_s, we_rise, we_fall, ale_act;
  assign oe_s    = ctrl_s[CTRL_OE];
  assign oe_rise = ctrl_rise[CTRL_OE];
  assign oe_fall = ctrl_fall[CTRL_OE];
  assign we_s    = ctrl_s[CTRL_WE];
  assign we_rise = ctrl_rise[CTRL_WE];
  assign we_fall = ctrl_fall[CTRL_WE];
  // Any sign of an ALE pulse, including its trailing edge.
  assign ale_act = |(ctrl_s[CTRL_ALE1:CTRL_ALE0] | ctrl_rise[CTRL_ALE1:CTRL_ALE0]
                     | ctrl_fall[CTRL_ALE1:CTRL_ALE0]);

  // ---------------- address decode ----------------
  logic [15:0]       addr_lo_reg, addr_hi_reg;
  logic [31:0]       addr;
  logic [MEM_AW-1:0] idx;
  logic              hit;

  assign addr = {addr_hi_reg, addr_lo_reg};
  assign idx  = addr[MEM_AW:1];
  assign hit  = (addr[31:MEM_AW+1] == BASE_ADDR[31:MEM_AW+1]);

  // ---------------- FSM ----------------
  state_e           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             isout_reg, isout_next;
  logic [15:0]      dout_reg, dout_next;
  logic [15:0]      rd_data_reg, wr_data_reg, dbg_dtr_reg;
  logic [1:0]       lane_reg;
  logic             bus_err_reg;
  logic             err_set, rd_load, wr_start, wr_commit;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    isout_next = isout_reg;
    dout_next  = dout_reg;
    err_set    = 1'b0;
    rd_load    = 1'b0;
    wr_start   = 1'b0;
    wr_commit  = 1'b0;

    if (ale_act && state_reg != ST_IDLE) err_set = 1'b1;

    unique case (state_reg)
      ST_IDLE: begin
        if (oe_s && we_s) begin
          err_set = 1'b1;
        end else if (oe_rise && hit) begin
          state_next = ST_RD_WAIT;
          cnt_next   = CNT_W'(READ_LAT);
          rd_load    = 1'b1;
        end else if (we_rise && hit) begin
          state_next = ST_WR_ACTIVE;
          wr_start   = 1'b1;
        end
      end
      ST_RD_WAIT: begin
        if (we_s) begin
          err_set    = 1'b1;
          state_next = ST_IDLE;
        end else if (oe_fall) begin
          state_next = ST_IDLE;
        end else if (cnt_reg == '0) begin
          state_next = ST_RD_DRIVE;
          isout_next = 1'b1;
          dout_next  = rd_data_reg;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      ST_RD_DRIVE: begin
        // A write strobe while we drive the pads is a contention hazard.
        if (we_s) begin
          err_set    = 1'b1;
          isout_next = 1'b0;
          state_next = ST_IDLE;
        end else if (oe_fall) begin
          isout_next = 1'b0;
          state_next = ST_IDLE;
        end
      end
      ST_WR_ACTIVE: begin
        if (we_fall) begin
          wr_commit  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      isout_reg   <= 1'b0;
      dout_reg    <= '0;
      bus_err_reg <= 1'b0;
      addr_lo_reg <= '0;
      addr_hi_reg <= '0;
      wr_data_reg <= '0;
      lane_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      isout_reg <= isout_next;
      dout_reg  <= dout_next;
      if (err_set) bus_err_reg <= 1'b1;
      // Transparent latches that close on the ALE falling edge.
      if (state_reg == ST_IDLE) begin
        if (ctrl_s[CTRL_ALE0]) addr_lo_reg <= din_s;
        if (ctrl_s[CTRL_ALE1]) addr_hi_reg <= din_s;
      end
      // Tracks the pads continuously; only the value before WE falls is used.
      wr_data_reg <= din_s;
      if (wr_start) lane_reg <= lane_enables(addr[0], bhe_s);
    end
  end

  // ---------------- halfword memory ----------------
  logic [15:0] mem [2**MEM_AW];

  always_ff @(posedge clk) begin
    if (wr_commit && !reset) begin
      if (lane_reg[LANE_LO_BIT]) mem[idx][7:0]  <= wr_data_reg[7:0];
      if (lane_reg[LANE_HI_BIT]) mem[idx][15:8] <= wr_data_reg[15:8];
    end
    if (rd_load) rd_data_reg <= mem[idx];
  end

  always_ff @(posedge clk) begin
    if (reset) dbg_dtr_reg <= '0;
    else       dbg_dtr_reg <= mem[dbg_addr];
  end

  assign dout    = dout_reg;
  assign isout   = isout_reg;
  assign dbg_dtr = dbg_dtr_reg;
  assign bus_err = bus_err_reg;

endmodule

// File: tb/tb_ext_bus_target.sv
module tb_ext_bus_target;

  localparam int          MEM_AW  = 8;
  localparam int          S       = 2;
  localparam int          L       = 4;
  localparam int          EXP_LAT = S + L + 1;
  localparam logic [31:0] BASE    = 32'h00FF_0000;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [15:0]       din = '0;
  logic [15:0]       dout;
  logic              isout;
  logic              ale0 = 1'b0, ale1 = 1'b0, oe = 1'b0, we = 1'b0, bhe = 1'b0;
  logic [MEM_AW-1:0] dbg_addr = '0;
  logic [15:0]       dbg_dtr;
  logic              bus_err;

  int checks = 0;
  int failures = 0;

  logic [15:0] model_mem [2**MEM_AW];

  always #5 clk = ~clk;

  ext_bus_target #(
    .MEM_AW(MEM_AW), .BASE_ADDR(BASE), .READ_LAT(L), .SYNC_STAGES(S)
  ) dut (
    .clk(clk), .reset(reset), .din(din), .dout(dout), .isout(isout),
    .ale0(ale0), .ale1(ale1), .oe(oe), .we(we), .bhe(bhe),
    .dbg_addr(dbg_addr), .dbg_dtr(dbg_dtr), .bus_err(bus_err)
  );

  // ---------------- reference model ----------------
  function automatic bit model_hit(input logic [31:0] a);
    return (a >> (MEM_AW + 1)) == (BASE >> (MEM_AW + 1));
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    return int'((a >> 1) % (1 << MEM_AW));
  endfunction

  task automatic model_write(input logic [31:0] a, input logic b, input logic [15:0] d);
    int i;
    if (model_hit(a)) begin
      i = model_idx(a);
      if (a % 2 == 0) model_mem[i] = {model_mem[i][15:8], d[7:0]};
      if (b)          model_mem[i] = {d[15:8], model_mem[i][7:0]};
    end
  endtask

  // ---------------- bus drivers (no checking) ----------------
  task automatic latch_addr(input logic [31:0] a);
    @(negedge clk);
    din = a[15:0]; ale0 = 1'b1;
    repeat (3) @(negedge clk);
    ale0 = 1'b0;
    @(negedge clk);
    din = a[31:16]; ale1 = 1'b1;
    repeat (3) @(negedge clk);
    ale1 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic b, input logic [15:0] d);
    latch_addr(a);
    din = d; bhe = b; we = 1'b1;
    repeat (6) @(negedge clk);
    we = 1'b0;
    repeat (6) @(negedge clk);
    bhe = 1'b0;
    model_write(a, b, d);
    $display("txn write addr=%08h bhe=%0d data=%04h", a, b, d);
  endtask

  // lat = -1 when isout never rose within the bound.
  task automatic bus_read(input logic [31:0] a, input bit do_latch,
                          output int lat, output logic [15:0] data, output logic isout_after);
    if (do_latch) latch_addr(a);
    else @(negedge clk);
    lat = -1; data = 'x;
    oe = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (isout === 1'b1) begin
        lat = k; data = dout;
        break;
      end
    end
    @(negedge clk);
    oe = 1'b0;
    repeat (6) @(negedge clk);
    isout_after = isout;
    $display("txn read  addr=%08h latency=%0d data=%04h", a, lat, data);
  endtask

  task automatic dbg_read(input int i, output logic [15:0] d);
    @(negedge clk);
    dbg_addr = MEM_AW'(i);
    @(posedge clk); #1;
    d = dbg_dtr;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; oe = 0; we = 0; ale0 = 0; ale1 = 0; bhe = 0; din = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (isout !== 1'b0) begin failures++; $display("FAIL reset_isout: got %b expected 0", isout); end
    checks++; if (dout !== 16'h0) begin failures++; $display("FAIL reset_dout: got %04h expected 0000", dout); end
    checks++; if (dbg_dtr !== 16'h0) begin failures++; $display("FAIL reset_dbg_dtr: got %04h expected 0000", dbg_dtr); end
    checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL reset_bus_err: got %b expected 0", bus_err); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_read();
    int lat; logic [15:0] d; logic ia;
    bus_write(32'h00FF_0002, 1'b1, 16'h00AA);
    bus_read(32'h00FF_0002, 1'b1, lat, d, ia);
    checks++; if (lat !== EXP_LAT) begin failures++; $display("FAIL wr_rd_latency: got %0d expected %0d", lat, EXP_LAT); end
    checks++; if (d !== 16'h00AA) begin failures++; $display("FAIL wr_rd_dout: got %04h expected 00aa", d); end
    checks++; if (ia !== 1'b0) begin failures++; $display("FAIL wr_rd_isout_release: got %b expected 0", ia); end
    dbg_read(1, d);
    checks++; if (d !== 16'h00AA) begin failures++; $display("FAIL wr_rd_dbg: got %04h expected 00aa", d); end
  endtask

  task automatic test_byte_lanes();
    int lat; logic [15:0] d; logic ia;
    bus_write(32'h00FF_0003, 1'b1, 16'h55FF);
    dbg_read(1, d);
    checks++; if (d !== 16'h55AA) begin failures++; $display("FAIL high_byte: got %04h expected 55aa", d); end
    bus_write(32'h00FF_0002, 1'b0, 16'h1234);
    dbg_read(1, d);
    checks++; if (d !== 16'h5534) begin failures++; $display("FAIL low_byte: got %04h expected 5534", d); end
    bus_read(32'h00FF_0002, 1'b1, lat, d, ia);
    checks++; if (d !== 16'h5534) begin failures++; $display("FAIL low_byte_bus: got %04h expected 5534", d); end
  endtask

  task automatic test_miss();
    int lat; logic [15:0] d; logic ia;
    bus_write(32'h0100_0002, 1'b1, 16'hDEAD);
    bus_read(32'h0100_0002, 1'b1, lat, d, ia);
    checks++; if (lat !== -1) begin failures++; $display("FAIL miss_isout: got latency %0d expected never driven", lat); end
    dbg_read(1, d);
    checks++; if (d !== model_mem[1]) begin failures++; $display("FAIL miss_mem: got %04h expected %04h", d, model_mem[1]); end
    checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL miss_bus_err: got %b expected 0", bus_err); end
  endtask

  task automatic test_read_abort();
    int lat; logic [15:0] d; logic ia; bit seen;
    latch_addr(32'h00FF_0002);
    oe = 1'b1;
    @(negedge clk);
    oe = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (isout !== 1'b0) seen = 1;
    end
    $display("txn read-abort addr=00ff0002");
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_isout: got driven expected never driven"); end
    checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL abort_bus_err: got %b expected 0", bus_err); end
    bus_read(32'h00FF_0002, 1'b0, lat, d, ia);
    checks++; if (lat !== EXP_LAT) begin failures++; $display("FAIL abort_then_read: got %0d expected %0d", lat, EXP_LAT); end
  endtask

  task automatic test_oe_we_conflict();
    logic [15:0] d; bit seen;
    latch_addr(32'h00FF_0002);
    din = 16'hBEEF; bhe = 1'b1; oe = 1'b1; we = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (isout !== 1'b0) seen = 1;
    end
    oe = 1'b0; we = 1'b0; bhe = 1'b0;
    repeat (6) @(negedge clk);
    $display("txn oe+we conflict addr=00ff0002");
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL conflict_isout: got driven expected never driven"); end
    checks++; if (bus_err !== 1'b1) begin failures++; $display("FAIL conflict_bus_err: got %b expected 1", bus_err); end
    dbg_read(1, d);
    checks++; if (d !== model_mem[1]) begin failures++; $display("FAIL conflict_mem: got %04h expected %04h", d, model_mem[1]); end
    apply_reset();
    checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL conflict_err_clear: got %b expected 0", bus_err); end
  endtask

  task automatic test_ale_in_write();
    int lat; logic [15:0] d; logic ia;
    latch_addr(32'h00FF_000A);
    din = 16'h3C5A; bhe = 1'b1; we = 1'b1;
    repeat (5) @(negedge clk);
    din = 16'h0040; ale0 = 1'b1;
    repeat (2) @(negedge clk);
    ale0 = 1'b0; din = 16'h3C5A;
    repeat (5) @(negedge clk);
    we = 1'b0;
    repeat (6) @(negedge clk);
    bhe = 1'b0;
    model_write(32'h00FF_000A, 1'b1, 16'h3C5A);
    $display("txn write with ale pulse addr=00ff000a data=3c5a");
    checks++; if (bus_err !== 1'b1) begin failures++; $display("FAIL ale_bus_err: got %b expected 1", bus_err); end
    dbg_read(5, d);
    checks++; if (d !== 16'h3C5A) begin failures++; $display("FAIL ale_write_target: got %04h expected 3c5a", d); end
    bus_read(32'h00FF_000A, 1'b0, lat, d, ia);
    checks++; if (d !== 16'h3C5A) begin failures++; $display("FAIL ale_addr_kept: got %04h expected 3c5a", d); end
    apply_reset();
  endtask

  task automatic test_reset_mid_op();
    logic [15:0] d; bit got;
    latch_addr(32'h00FF_0002);
    oe = 1'b1;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (isout === 1'b1) begin got = 1; break; end
    end
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL rst_rd_reach_drive: got no drive expected drive"); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (isout !== 1'b0) begin failures++; $display("FAIL rst_rd_isout: got %b expected 0", isout); end
    @(negedge clk);
    oe = 1'b0;
    reset = 1'b0;
    repeat (6) @(negedge clk);
    $display("txn reset during read drive");
    latch_addr(32'h00FF_0002);
    din = 16'hFFFF; bhe = 1'b1; we = 1'b1;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    we = 1'b0; bhe = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    $display("txn reset during write");
    dbg_read(1, d);
    checks++; if (d !== model_mem[1]) begin failures++; $display("FAIL rst_wr_mem: got %04h expected %04h", d, model_mem[1]); end
    checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL rst_wr_bus_err: got %b expected 0", bus_err); end
  endtask

  task automatic test_random();
    int lat, i; logic [15:0] d, pre, wd; logic ia, b, a0; logic [31:0] a; bit miss;
    for (int n = 0; n < 12; n++) begin
      i    = int'($urandom_range(0, (1 << MEM_AW) - 1));
      pre  = 16'($urandom);
      wd   = 16'($urandom);
      b    = 1'($urandom_range(0, 1));
      a0   = 1'($urandom_range(0, 1));
      miss = ($urandom_range(0, 3) == 0);
      bus_write(BASE + 32'(i * 2), 1'b1, pre);
      a = (miss ? 32'h0123_0000 : BASE) + 32'(i * 2) + 32'(a0);
      bus_write(a, b, wd);
      bus_read(BASE + 32'(i * 2), 1'b1, lat, d, ia);
      checks++; if (lat !== EXP_LAT) begin failures++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", n, lat, EXP_LAT); end
      checks++; if (d !== model_mem[i]) begin failures++; $display("FAIL rand_bus_data[%0d]: got %04h expected %04h", n, d, model_mem[i]); end
      dbg_read(i, d);
      checks++; if (d !== model_mem[i]) begin failures++; $display("FAIL rand_dbg_data[%0d]: got %04h expected %04h", n, d, model_mem[i]); end
    end
    checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL rand_bus_err: got %b expected 0", bus_err); end
  endtask

  initial begin
    for (int k = 0; k < (1 << MEM_AW); k++) model_mem[k] = '0;
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_miss();
    test_read_abort();
    test_oe_we_conflict();
    test_ale_in_write();
    test_reset_mid_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
